// File: rtl/cpu_clk_ctrl_if.sv
// cpu_clk_ctrl_if: switch/button inputs and clock-enable outputs of the CPU clock controller
//   run_sw   : 1 = free-run, 0 = halt (asynchronous level)
//   step_btn : bouncy push-button, a press requests one step
//   rate_sel : RUN period select, period = 4 << (3*rate_sel)
//   cpu_ce   : one-cycle clock-enable pulse to the core
//   mode     : 0 = HALT, 1 = RUN, 2 = STEP
//   ce_count : running count of cpu_ce pulses, wraps at 16 bits
interface cpu_clk_ctrl_if;
  logic        run_sw;
  logic        step_btn;
  logic [2:0]  rate_sel;
  logic        cpu_ce;
  logic [1:0]  mode;
  logic [15:0] ce_count;
  modport master (output run_sw, step_btn, rate_sel, input cpu_ce, mode, ce_count);
  modport slave (input run_sw, step_btn, rate_sel, output cpu_ce, mode, ce_count);
endinterface

// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: run/halt/single-step clock-enable generator for the processor core
//   clk_in : board clock, the only clock in the block
//   rst    : asynchronous active-high reset
//   bus    : cpu_clk_ctrl_if slave (run_sw, step_btn, rate_sel in; cpu_ce, mode, ce_count out)
module cpu_clk_ctrl #(
  parameter int DB_CYCLES = 1000000,
  parameter int CNT_W = 24
) (
  input logic clk_in,
  input logic rst,
  cpu_clk_ctrl_if.slave bus
);
  localparam int DB_W = DB_CYCLES > 1 ? $clog2(DB_CYCLES) : 1;
  typedef enum logic [1:0] {HALT = 2'd0, RUN = 2'd1, STEP = 2'd2} state_t;
  state_t r_state, w_nxt;
  logic r_run_s1, r_run_s2, r_btn_s1, r_btn_s2, r_db, r_db_p, r_ce;
  logic [DB_W-1:0] r_db_cnt;
  logic [2:0] r_rate;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_per;
  logic [15:0] r_count;
  logic [4:0] w_sh;
  logic w_press, w_chg, w_ce_nxt, w_db_hit;
  assign w_sh = {2'b0, r_rate} + {1'b0, r_rate, 1'b0};
  assign w_per = CNT_W'(4) << w_sh;
  // A rate change is seen against the registered copy so the counter restarts on the edge that loads the new rate
  assign w_chg = bus.rate_sel != r_rate;
  assign w_press = r_db & ~r_db_p;
  assign w_db_hit = r_db_cnt == DB_W'(DB_CYCLES - 1);
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_run_s1 <= 1'b0;
      r_run_s2 <= 1'b0;
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
      r_db <= 1'b0;
      r_db_p <= 1'b0;
      r_db_cnt <= '0;
      r_rate <= '0;
    end else begin
      r_run_s1 <= bus.run_sw;
      r_run_s2 <= r_run_s1;
      r_btn_s1 <= bus.step_btn;
      r_btn_s2 <= r_btn_s1;
      r_db_p <= r_db;
      r_rate <= bus.rate_sel;
      r_db <= (r_btn_s2 != r_db && w_db_hit) ? r_btn_s2 : r_db;
      r_db_cnt <= (r_btn_s2 == r_db || w_db_hit) ? '0 : r_db_cnt + 1'b1;
    end
  end
  // RUN wins over a simultaneous press; presses outside HALT are simply not looked at
  always_comb begin
    w_nxt = r_state;
    w_cnt_nxt = '0;
    w_ce_nxt = 1'b0;
    case (r_state)
      HALT: w_nxt = r_run_s2 ? RUN : (w_press ? STEP : HALT);
      RUN: begin
        if (!r_run_s2) w_nxt = HALT;
        else if (!w_chg) begin
          w_ce_nxt = r_cnt == w_per - 1'b1;
          w_cnt_nxt = w_ce_nxt ? '0 : r_cnt + 1'b1;
        end
      end
      default: w_nxt = HALT;
    endcase
    w_ce_nxt = w_ce_nxt | (w_nxt == STEP);
  end
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state <= HALT;
      r_cnt <= '0;
      r_ce <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt <= w_cnt_nxt;
      r_ce <= w_ce_nxt;
      r_count <= r_count + 16'(w_ce_nxt);
    end
  end
  assign bus.cpu_ce = r_ce;
  assign bus.mode = r_state;
  assign bus.ce_count = r_count;
endmodule
